reg_seq_ctrl: RTL and testbench

//   Sequencer on the write/issue side of the 2-entry, 4-bit register bank.

---
 rtl/reg_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: sequencer on the write/issue side of a small register bank.
// It takes one instruction at a time over a valid/ready handshake. It drives
// the bank read/write addresses and the ALU op code. It collects the ALU
// result (EXEC) or the bank read data (MOV) and writes it back with a single
// strobe.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready is combinational)
//   instr_op                 00 NOP, 01 LOADI, 10 EXEC, 11 MOV
//   instr_dst/src1/src2      register addresses
//   instr_imm                LOADI immediate
//   instr_alu_op             ALU op code for EXEC
//   rd_reg1                  bank read port 1 data (MOV source)
//   alu_result               ALU output (EXEC source)
//   ra_reg1/ra_reg2          bank read addresses
//   wa_reg/wd_reg/w_enable   bank write port
//   alu_op                   ALU op code
//   done                     one-cycle pulse when an instruction retires
module reg_seq_ctrl #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ADDR_W  = 1,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_src1,
  input  logic [ADDR_W-1:0] instr_src2,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic [3:0]        instr_alu_op,
  input  logic [DATA_W-1:0] rd_reg1,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] ra_reg1,
  output logic [ADDR_W-1:0] ra_reg2,
  output logic [ADDR_W-1:0] wa_reg,
  output logic [DATA_W-1:0] wd_reg,
  output logic              w_enable,
  output logic [3:0]        alu_op,
  output logic              done
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  localparam logic [1:0] OP_MOV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WT   = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [CNT_W-1:0]   wait_cnt;

  // Ready is combinational so the handshake completes in the IDLE cycle itself.
  assign instr_ready = (state == IDLE) && !rst;

  // Sequencer state and registered bank/ALU outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      dst_q    <= '0;
      wait_cnt <= '0;
      ra_reg1  <= '0;
      ra_reg2  <= '0;
      wa_reg   <= '0;
      wd_reg   <= '0;
      w_enable <= 1'b0;
      alu_op   <= '0;
      done     <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are only raised on the edge into WB.
      w_enable <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            dst_q <= instr_dst;
            case (instr_op)
              OP_NOP: begin
                done  <= 1'b1;
                state <= WB;
              end
              OP_LOADI: begin
                wa_reg   <= instr_dst;
                wd_reg   <= instr_imm;
                w_enable <= 1'b1;
                done     <= 1'b1;
                state    <= WB;
              end
              OP_EXEC: begin
                ra_reg1 <= instr_src1;
                ra_reg2 <= instr_src2;
                alu_op  <= instr_alu_op;
                state   <= RD;
              end
              default: begin
                // MOV: only read port 1 matters, alu_op keeps its last value.
                ra_reg1 <= instr_src1;
                ra_reg2 <= instr_src2;
                state   <= RD;
              end
            endcase
          end
        end
        RD: begin
          // WT lasts wait_cnt+1 cycles; MOV only needs the bank read register.
          wait_cnt <= (op_q == OP_MOV) ? '0 : CNT_W'(ALU_LAT);
          state    <= WT;
        end
        WT: begin
          if (wait_cnt == '0) begin
            wd_reg   <= (op_q == OP_MOV) ? rd_reg1 : alu_result;
            wa_reg   <= dst_q;
            w_enable <= 1'b1;
            done     <= 1'b1;
            state    <= WB;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed bench for reg_seq_ctrl: four instances with ALU_LAT 0..3 share one
// stimulus stream; each has a small 2-entry bank model feeding rd_reg1.
module tb_reg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [1:0] instr_op;
  logic       instr_dst, instr_src1, instr_src2;
  logic [3:0] instr_imm, instr_alu_op, alu_result;

  logic [3:0]      rdy, we, dn, ra1, ra2, wa;
  logic [3:0][3:0] wd, aop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    logic [3:0] bank [2];
    logic [3:0] rd_q;

    reg_seq_ctrl #(.DATA_W(4), .ADDR_W(1), .ALU_LAT(g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (rdy[g]),
      .instr_op     (instr_op),
      .instr_dst    (instr_dst),
      .instr_src1   (instr_src1),
      .instr_src2   (instr_src2),
      .instr_imm    (instr_imm),
      .instr_alu_op (instr_alu_op),
      .rd_reg1      (rd_q),
      .alu_result   (alu_result),
      .ra_reg1      (ra1[g]),
      .ra_reg2      (ra2[g]),
      .wa_reg       (wa[g]),
      .wd_reg       (wd[g]),
      .w_enable     (we[g]),
      .alu_op       (aop[g]),
      .done         (dn[g])
    );

    // Bank model: synchronous write, registered read port 1.
    always @(posedge clk) begin
      if (we[g]) bank[wa[g]] <= wd[g];
      rd_q <= bank[ra1[g]];
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one instruction in the low phase; it is accepted at the next edge.
  task automatic issue(input logic [1:0] op, input logic dst, input logic s1,
                       input logic s2, input logic [3:0] imm, input logic [3:0] aluop);
    chk("ready_before_issue", 8'(rdy), 8'hF);
    instr_op     = op;
    instr_dst    = dst;
    instr_src1   = s1;
    instr_src2   = s2;
    instr_imm    = imm;
    instr_alu_op = aluop;
    instr_valid  = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr_op     = 2'b00;
    instr_dst    = 1'b0;
    instr_src1   = 1'b0;
    instr_src2   = 1'b0;
    instr_imm    = 4'h0;
    instr_alu_op = 4'h0;
    alu_result   = 4'h0;

    // Reset state
    cyc(); cyc();
    chk("rst_ready", 8'(rdy), 8'h0);
    chk("rst_wen",   8'(we),  8'h0);
    chk("rst_done",  8'(dn),  8'h0);
    chk("rst_ra1",   8'(ra1), 8'h0);
    chk("rst_ra2",   8'(ra2), 8'h0);
    chk("rst_wa",    8'(wa),  8'h0);
    chk("rst_wd1",   8'(wd[1]),  8'h0);
    chk("rst_aop1",  8'(aop[1]), 8'h0);
    rst = 1'b0;
    #1 chk("rel_ready", 8'(rdy), 8'hF);

    // 1: LOADI r1 <= A
    issue(2'b01, 1'b1, 1'b0, 1'b0, 4'hA, 4'h0);
    cyc();
    chk("ld_wen",   8'(we[1]), 8'h1);
    chk("ld_wa",    8'(wa[1]), 8'h1);
    chk("ld_wd",    8'(wd[1]), 8'hA);
    chk("ld_done",  8'(dn[1]), 8'h1);
    chk("ld_ready", 8'(rdy[1]), 8'h0);
    cyc();
    chk("ld_n2_ready", 8'(rdy[1]), 8'h1);
    chk("ld_n2_wen",   8'(we[1]),  8'h0);
    chk("ld_n2_done",  8'(dn[1]),  8'h0);

    // 2: EXEC r1 <= alu(r0, r1) op 2, ALU gives 7
    alu_result = 4'h7;
    issue(2'b10, 1'b1, 1'b0, 1'b1, 4'h0, 4'h2);
    cyc();
    chk("ex_rd_ra1", 8'(ra1[1]), 8'h0);
    chk("ex_rd_ra2", 8'(ra2[1]), 8'h1);
    chk("ex_rd_aop", 8'(aop[1]), 8'h2);
    chk("ex_rd_wen", 8'(we[1]),  8'h0);
    chk("ex_rd_rdy", 8'(rdy[1]), 8'h0);
    cyc();
    chk("ex_wt1_wen", 8'(we[1]), 8'h0);
    cyc();
    chk("ex_wt2_wen", 8'(we[1]), 8'h0);
    chk("ex_wt2_done", 8'(dn[1]), 8'h0);
    cyc();
    chk("ex_wb_wen",  8'(we[1]), 8'h1);
    chk("ex_wb_wa",   8'(wa[1]), 8'h1);
    chk("ex_wb_wd",   8'(wd[1]), 8'h7);
    chk("ex_wb_done", 8'(dn[1]), 8'h1);
    cyc();
    chk("ex_n5_ready", 8'(rdy[1]), 8'h1);
    chk("ex_n5_wen",   8'(we[1]),  8'h0);
    chk("ex_hold_ra2", 8'(ra2[1]), 8'h1);
    chk("ex_hold_aop", 8'(aop[1]), 8'h2);
    cyc(); cyc(); cyc();

    // 3: LOADI r0 <= 5, then MOV r1 <= r0
    issue(2'b01, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0);
    cyc();
    chk("ld5_wd", 8'(wd[1]), 8'h5);
    cyc();
    issue(2'b11, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    cyc();
    chk("mov_rd_ra1", 8'(ra1[1]), 8'h0);
    chk("mov_rd_wen", 8'(we[1]),  8'h0);
    cyc();
    chk("mov_wt_wen", 8'(we[1]), 8'h0);
    cyc();
    chk("mov_wb_wen",  8'(we), 8'hF);
    chk("mov_wb_wa",   8'(wa[1]), 8'h1);
    chk("mov_wb_wd",   8'(wd[1]), 8'h5);
    chk("mov_wb_done", 8'(dn[1]), 8'h1);
    cyc();
    chk("mov_readback", 8'(gen_dut[1].bank[1]), 8'h5);
    chk("mov_n4_ready", 8'(rdy[1]), 8'h1);

    // 4: NOP then LOADI r0 <= C with valid held high
    chk("nop_ready", 8'(rdy), 8'hF);
    instr_op    = 2'b00;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_op  = 2'b01;
    instr_dst = 1'b0;
    instr_imm = 4'hC;
    cyc();
    chk("nop_done",  8'(dn[1]),  8'h1);
    chk("nop_wen",   8'(we[1]),  8'h0);
    chk("nop_ready1", 8'(rdy[1]), 8'h0);
    cyc();
    chk("nop_n2_wen",   8'(we[1]),  8'h0);
    chk("nop_n2_done",  8'(dn[1]),  8'h0);
    chk("nop_n2_ready", 8'(rdy[1]), 8'h1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    cyc();
    chk("nl_wen",  8'(we[1]), 8'h1);
    chk("nl_wa",   8'(wa[1]), 8'h0);
    chk("nl_wd",   8'(wd[1]), 8'hC);
    chk("nl_done", 8'(dn[1]), 8'h1);
    cyc();

    // 5: ALU wraps F+1 to 0; WB lands at N+3+ALU_LAT for each instance
    alu_result = 4'(4'hF + 4'h1);
    issue(2'b10, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("lat%0d_k%0d_wen", g, k), 8'(we[g]), (k == 3 + g) ? 8'h1 : 8'h0);
        if (k == 3 + g) begin
          chk($sformatf("lat%0d_wd", g), 8'(wd[g]), 8'h0);
          chk($sformatf("lat%0d_done", g), 8'(dn[g]), 8'h1);
        end
      end
    end
    chk("sweep_ready", 8'(rdy), 8'hF);

    // 6: reset during WT of an EXEC
    alu_result = 4'h9;
    issue(2'b10, 1'b1, 1'b1, 1'b1, 4'h0, 4'h6);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_wt_wen",   8'(we),  8'h0);
    chk("rst_wt_done",  8'(dn),  8'h0);
    chk("rst_wt_ra1",   8'(ra1), 8'h0);
    chk("rst_wt_wa",    8'(wa),  8'h0);
    chk("rst_wt_wd1",   8'(wd[1]),  8'h0);
    chk("rst_wt_aop1",  8'(aop[1]), 8'h0);
    chk("rst_wt_ready", 8'(rdy), 8'h0);
    cyc();
    chk("rst_hold_ready", 8'(rdy), 8'h0);
    rst = 1'b0;
    #1 chk("rst_rel_ready", 8'(rdy), 8'hF);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("post_rst%0d_wen", k), 8'(we), 8'h0);
      chk($sformatf("post_rst%0d_done", k), 8'(dn), 8'h0);
    end

    // Recovery: LOADI after the aborted EXEC
    issue(2'b01, 1'b1, 1'b0, 1'b0, 4'h3, 4'h0);
    cyc();
    chk("rec_wen", 8'(we[1]), 8'h1);
    chk("rec_wd",  8'(wd[1]), 8'h3);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
